f1_reaction_timer: RTL
======================

// Module: f1_reaction_timer
// PURPOSE
//  Downstream consumer of the F1 start-light sequence. Watches the light bus
//  (8'h01..8'hFF, then 8'h00 at lights-out) and a driver push-button. Measures
//  reaction time in ms ticks from lights-out to the press, and flags jump starts
//  and timeouts. Result is held for display until the next light sequence begins.
// PARAMETERS
//  WIDTH       8     light bus width; "all on" = {WIDTH{1'b1}}, first light = 1
//  CNT_WIDTH   16    reaction counter width (ms)
//  TIMEOUT_MS  9999  count at which timing aborts with timeout=1
// PORTS
//  clk       in   1          system clock
//  rst       in   1          asynchronous, active-low reset
//  lights    in   WIDTH      light pattern from the F1 light sequencer
//  tick      in   1          1-cycle strobe, one per ms (from clktick)
//  trigger   in   1          raw driver button, asynchronous, active-high
//  react_ms  out  CNT_WIDTH  measured reaction time; valid when valid=1
//  valid     out  1          result held (state DONE)
//  jump      out  1          press occurred before lights-out
//  timeout   out  1          no press before TIMEOUT_MS
//  busy      out  1          state is ARMED or TIMING
// BEHAVIOUR
//  - Reset (any time, async): state=IDLE; react_ms=0; valid/jump/timeout/busy=0;
//    synchroniser flops=0. Mid-measurement reset discards the measurement.
//  - trigger: 2-flop synchroniser, then rising-edge detect -> press (1 cycle).
//    Press latency is 3 clk from the trigger edge. Held button gives one press only.
//  - FSM:
//    IDLE   : lights=={WIDTH{1}} -> ARMED. Press ignored.
//    ARMED  : press -> DONE, jump=1, react_ms=0.
//             else lights==0 -> TIMING, counter=0.
//    TIMING : tick -> counter+1. Press -> DONE, react_ms=counter (+1 if tick in same cycle).
//             counter==TIMEOUT_MS -> DONE, timeout=1, react_ms=TIMEOUT_MS.
//             Timeout takes precedence over a same-cycle press.
//    DONE   : outputs held. lights==1 (new sequence) -> IDLE, clearing valid/jump/timeout.
//             lights=={WIDTH{1}} -> ARMED directly.
//  - Counter is unsigned and never wraps. TIMEOUT_MS must be < 2**CNT_WIDTH.
//  - Outputs are registered. valid/jump/timeout rise 1 clk after the deciding event.
// CONFIGURATION
//  F1_REACT_BCD_EN defined:
//   - adds output react_bcd[15:0] (4 BCD digits, ms). It is a BCD counter that
//     increments with counter and saturates at 9999.
//   - it has the same reset and clear points as react_ms.
//  F1_REACT_BCD_EN undefined: the port and logic are absent; binary output only.
// STRUCTURE
//  - f1_pkg:
//    - typedef enum logic [1:0] {IDLE, ARMED, TIMING, DONE} react_state_t
//    - localparam BCD_DIGITS=4
//  - Sub-module bcd_counter4 (clk, rst, clr, inc -> bcd[15:0]). It is instantiated
//    only under F1_REACT_BCD_EN.
// TESTING
//  1. rst low mid-TIMING (counter=37) -> all outputs 0 at once, state IDLE after release.
//  2. Lights 01..FF, then 00. 250 ticks, then trigger
//     -> valid=1, react_ms=250, jump=0, timeout=0.
//  3. Trigger while lights=FF -> valid=1, jump=1, react_ms=0. Later lights=00 -> no change.
//  4. Lights-out, no press, TIMEOUT_MS=20 -> timeout=1, react_ms=20 one clk after the 20th tick.
//  5. Press and tick in same cycle at counter=9 -> react_ms=10. Holding trigger gives no second event.
//  6. In DONE, lights=01 -> valid=0. With F1_REACT_BCD_EN and 1234 ticks -> react_bcd=16'h1234.

Source files
------------

// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 reaction timer.
package f1_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, TIMING, DONE} react_state_t;

  localparam int BCD_DIGITS = 4;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear; saturates at 9999.
module bcd_counter4
  import f1_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    inc,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  logic [4*BCD_DIGITS-1:0] bcd_nxt;
  logic                    carry;
  logic                    sat;

  assign sat = (bcd == {BCD_DIGITS{4'd9}});

  always_comb begin
    bcd_nxt = bcd;
    carry   = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (carry) begin
        if (bcd[4*i +: 4] == 4'd9) begin
          bcd_nxt[4*i +: 4] = 4'd0;
        end else begin
          bcd_nxt[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd <= '0;
    end else if (clr) begin
      bcd <= '0;
    end else if (inc && !sat) begin
      bcd <= bcd_nxt;
    end
  end

endmodule

// File: rtl/f1_reaction_timer.sv
// Reaction timer fed by the F1 start-light bus: times lights-out to button press.
// Defining F1_REACT_BCD_EN adds the react_bcd output driven by bcd_counter4.
module f1_reaction_timer
  import f1_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int TIMEOUT_MS = 9999
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     lights,
  input  logic                 tick,
  input  logic                 trigger,
  output logic [CNT_WIDTH-1:0] react_ms,
  output logic                 valid,
  output logic                 jump,
  output logic                 timeout,
  output logic                 busy
`ifdef F1_REACT_BCD_EN
  ,
  output logic [15:0]          react_bcd
`endif
);

  // state  | meaning
  // IDLE   | waiting for all lights on
  // ARMED  | all lights on; a press here is a jump start
  // TIMING | lights out; counting ms ticks until press or timeout
  // DONE   | result held until a new light pattern starts a sequence

  localparam logic [WIDTH-1:0]     ALL_ON = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]     FIRST  = WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TMO    = CNT_WIDTH'(TIMEOUT_MS);

  react_state_t         state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt, react_nxt;
  logic                 valid_nxt, jump_nxt, timeout_nxt, busy_nxt;
  logic                 sync1, sync2, sync3, press;
  logic [WIDTH-1:0]     lights_q;
  logic                 lights_new;
  logic                 bcd_clr, bcd_inc;

  assign press      = sync2 & ~sync3;
  // DONE reacts to a pattern arriving, so a jump start taken while the bus
  // still shows all-on stays on display instead of re-arming immediately.
  assign lights_new = (lights != lights_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      react_ms <= '0;
      valid    <= 1'b0;
      jump     <= 1'b0;
      timeout  <= 1'b0;
      busy     <= 1'b0;
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      lights_q <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      react_ms <= react_nxt;
      valid    <= valid_nxt;
      jump     <= jump_nxt;
      timeout  <= timeout_nxt;
      busy     <= busy_nxt;
      sync1    <= trigger;
      sync2    <= sync1;
      sync3    <= sync2;
      lights_q <= lights;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    react_nxt   = react_ms;
    valid_nxt   = valid;
    jump_nxt    = jump;
    timeout_nxt = timeout;
    bcd_clr     = 1'b0;
    bcd_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (lights == ALL_ON) state_nxt = ARMED;
      end
      ARMED: begin
        if (press) begin
          state_nxt = DONE;
          valid_nxt = 1'b1;
          jump_nxt  = 1'b1;
          react_nxt = '0;
        end else if (lights == '0) begin
          state_nxt = TIMING;
          cnt_nxt   = '0;
          bcd_clr   = 1'b1;
        end
      end
      TIMING: begin
        if (cnt == TMO) begin
          state_nxt   = DONE;
          valid_nxt   = 1'b1;
          timeout_nxt = 1'b1;
          react_nxt   = TMO;
        end else begin
          if (tick) begin
            cnt_nxt = cnt + CNT_WIDTH'(1);
            bcd_inc = 1'b1;
          end
          if (press) begin
            state_nxt = DONE;
            valid_nxt = 1'b1;
            react_nxt = cnt + CNT_WIDTH'(tick);
          end
        end
      end
      DONE: begin
        if (lights_new && (lights == FIRST || lights == ALL_ON)) begin
          state_nxt   = (lights == FIRST) ? IDLE : ARMED;
          valid_nxt   = 1'b0;
          jump_nxt    = 1'b0;
          timeout_nxt = 1'b0;
          react_nxt   = '0;
          bcd_clr     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == ARMED) || (state_nxt == TIMING);
  end

`ifdef F1_REACT_BCD_EN
  bcd_counter4 u_bcd (
    .clk (clk),
    .rst (rst),
    .clr (bcd_clr),
    .inc (bcd_inc),
    .bcd (react_bcd)
  );
`else
  logic unused_bcd;
  assign unused_bcd = bcd_clr ^ bcd_inc;
`endif

endmodule
